// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory stage: FSM state encoding and access classification.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StHalt = 2'd2
  } mem_state_e;

  localparam int unsigned DefaultDataW      = 16;
  localparam int unsigned DefaultTimeoutCyc = 16;

  // An access is rejected when both op bits are set, or when a memory op is unaligned or
  // rides on a halt instruction.
  function automatic logic is_bad_access(input logic addr_lsb, input logic mem_wrt,
                                         input logic mem_read, input logic n_halt);
    return (mem_wrt & mem_read) | ((mem_wrt | mem_read) & (addr_lsb | ~n_halt));
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expire is high once the count hits TIMEOUT_CYC-1.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] cnt_q;

  assign expire = (cnt_q == CntW'(TIMEOUT_CYC - 1));

  // Saturate at the expire value so a stalled caller never wraps back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: captures execute results, runs a req/done data-memory handshake with a
// timeout, and emits a one-cycle result pulse to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = DefaultDataW,
  parameter int unsigned TIMEOUT_CYC = DefaultTimeoutCyc
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic              ex_mem_wrt,
  input  logic              ex_mem_read,
  input  logic              ex_n_halt,
  output logic              stall_ex,
  output logic              dm_req,
  output logic              dm_wr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_done,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_err,
  output logic              halted
);

  mem_state_e state_q;

  logic capture;
  logic is_mem;
  logic is_halt;
  logic bad_access;
  logic mem_start;
  logic timer_expire;

  always_comb begin
    capture    = (state_q == StIdle) && ex_valid;
    is_mem     = ex_mem_wrt | ex_mem_read;
    is_halt    = ~ex_n_halt;
    bad_access = is_bad_access(ex_alu_out[0], ex_mem_wrt, ex_mem_read, ex_n_halt);
    mem_start  = capture && is_mem && !bad_access;
  end

  assign stall_ex = (state_q == StBusy);

  mem_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (mem_start),
    .en     (stall_ex),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      dm_req   <= 1'b0;
      dm_wr    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_err   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            if (bad_access) begin
              wb_valid <= 1'b1;
              wb_err   <= 1'b1;
              wb_data  <= ex_alu_out;
              // A halt stays a halt even when its memory op is rejected.
              if (is_halt) begin
                halted  <= 1'b1;
                state_q <= StHalt;
              end
            end else if (is_halt) begin
              wb_valid <= 1'b1;
              wb_err   <= 1'b0;
              wb_data  <= ex_alu_out;
              halted   <= 1'b1;
              state_q  <= StHalt;
            end else if (is_mem) begin
              state_q  <= StBusy;
              dm_req   <= 1'b1;
              dm_wr    <= ex_mem_wrt;
              dm_addr  <= ex_alu_out;
              dm_wdata <= ex_rt_data;
            end else begin
              wb_valid <= 1'b1;
              wb_err   <= 1'b0;
              wb_data  <= ex_alu_out;
            end
          end
        end
        StBusy: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (dm_done) begin
            state_q  <= StIdle;
            dm_req   <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b0;
            wb_data  <= dm_wr ? dm_addr : dm_rdata;
          end else if (timer_expire) begin
            state_q  <= StIdle;
            dm_req   <= 1'b0;
            wb_valid <= 1'b1;
            wb_err   <= 1'b1;
            wb_data  <= '0;
          end
        end
        StHalt: begin
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store handshake, errors, timeout,
// asynchronous reset mid-access, and sticky halt.
module tb_mem_stage;

  localparam int unsigned DataW   = 16;
  localparam int unsigned Timeout = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid;
  logic [DataW-1:0] ex_alu_out;
  logic [DataW-1:0] ex_rt_data;
  logic             ex_mem_wrt;
  logic             ex_mem_read;
  logic             ex_n_halt;
  logic             stall_ex;
  logic             dm_req;
  logic             dm_wr;
  logic [DataW-1:0] dm_addr;
  logic [DataW-1:0] dm_wdata;
  logic [DataW-1:0] dm_rdata;
  logic             dm_done;
  logic             wb_valid;
  logic [DataW-1:0] wb_data;
  logic             wb_err;
  logic             halted;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_stage #(
    .DATA_W      (DataW),
    .TIMEOUT_CYC (Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_alu_out  (ex_alu_out),
    .ex_rt_data  (ex_rt_data),
    .ex_mem_wrt  (ex_mem_wrt),
    .ex_mem_read (ex_mem_read),
    .ex_n_halt   (ex_n_halt),
    .stall_ex    (stall_ex),
    .dm_req      (dm_req),
    .dm_wr       (dm_wr),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_done     (dm_done),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_err      (wb_err),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DataW-1:0] alu, input logic [DataW-1:0] rt,
                       input logic wrt, input logic rd, input logic n_halt);
    ex_valid    = v;
    ex_alu_out  = alu;
    ex_rt_data  = rt;
    ex_mem_wrt  = wrt;
    ex_mem_read = rd;
    ex_n_halt   = n_halt;
  endtask

  task automatic idle_in();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int req_cycles;
    int wb_count;
    int req_seen;

    rst      = 1'b1;
    dm_rdata = '0;
    dm_done  = 1'b0;
    idle_in();
    #1;
    check("reset_wb_valid", 32'(wb_valid), 32'd0);
    check("reset_dm_req", 32'(dm_req), 32'd0);
    check("reset_stall", 32'(stall_ex), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_wb_data", 32'(wb_data), 32'd0);
    step();
    step();
    rst = 1'b0;

    // 1: ALU op passes straight through
    drive(1'b1, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
    step();
    idle_in();
    check("alu_wb_valid", 32'(wb_valid), 32'd1);
    check("alu_wb_data", 32'(wb_data), 32'h1234);
    check("alu_wb_err", 32'(wb_err), 32'd0);
    check("alu_stall", 32'(stall_ex), 32'd0);
    check("alu_dm_req", 32'(dm_req), 32'd0);
    step();
    check("alu_pulse_end", 32'(wb_valid), 32'd0);
    check("alu_data_hold", 32'(wb_data), 32'h1234);

    // 2: load, done in third BUSY cycle
    drive(1'b1, 16'h0040, 16'h0000, 1'b0, 1'b1, 1'b1);
    step();
    idle_in();
    check("ld_stall_c1", 32'(stall_ex), 32'd1);
    check("ld_dm_req", 32'(dm_req), 32'd1);
    check("ld_dm_wr", 32'(dm_wr), 32'd0);
    check("ld_dm_addr", 32'(dm_addr), 32'h0040);
    check("ld_no_wb", 32'(wb_valid), 32'd0);
    step();
    check("ld_stall_c2", 32'(stall_ex), 32'd1);
    step();
    check("ld_stall_c3", 32'(stall_ex), 32'd1);
    dm_done  = 1'b1;
    dm_rdata = 16'hBEEF;
    step();
    dm_done  = 1'b0;
    dm_rdata = '0;
    check("ld_wb_valid", 32'(wb_valid), 32'd1);
    check("ld_wb_data", 32'(wb_data), 32'hBEEF);
    check("ld_wb_err", 32'(wb_err), 32'd0);
    check("ld_stall_rel", 32'(stall_ex), 32'd0);
    check("ld_req_drop", 32'(dm_req), 32'd0);

    // 3: unaligned store is rejected without a request
    drive(1'b1, 16'h0041, 16'h5555, 1'b1, 1'b0, 1'b1);
    step();
    idle_in();
    check("unal_wb_valid", 32'(wb_valid), 32'd1);
    check("unal_wb_err", 32'(wb_err), 32'd1);
    check("unal_wb_data", 32'(wb_data), 32'h0041);
    check("unal_dm_req", 32'(dm_req), 32'd0);
    check("unal_stall", 32'(stall_ex), 32'd0);

    // 3b: illegal op (both bits) also rejected
    drive(1'b1, 16'h0060, 16'h0000, 1'b1, 1'b1, 1'b1);
    step();
    idle_in();
    check("ill_wb_err", 32'(wb_err), 32'd1);
    check("ill_dm_req", 32'(dm_req), 32'd0);

    // 4: load with no done times out after exactly Timeout request cycles
    drive(1'b1, 16'h0080, 16'h0000, 1'b0, 1'b1, 1'b1);
    step();
    idle_in();
    req_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (!dm_req) break;
      req_cycles++;
      step();
    end
    check("to_req_cycles", 32'(req_cycles), 32'd4);
    check("to_wb_valid", 32'(wb_valid), 32'd1);
    check("to_wb_err", 32'(wb_err), 32'd1);
    check("to_wb_data", 32'(wb_data), 32'h0000);
    check("to_stall_rel", 32'(stall_ex), 32'd0);

    // 5: store in BUSY, async reset two cycles in
    drive(1'b1, 16'h0100, 16'hABCD, 1'b1, 1'b0, 1'b1);
    step();
    idle_in();
    check("st_dm_wr", 32'(dm_wr), 32'd1);
    check("st_dm_wdata", 32'(dm_wdata), 32'hABCD);
    step();
    check("st_busy_c2", 32'(dm_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dm_req", 32'(dm_req), 32'd0);
    check("arst_stall", 32'(stall_ex), 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 16'h0200, 16'h0000, 1'b0, 1'b1, 1'b1);
    step();
    idle_in();
    check("post_rst_addr", 32'(dm_addr), 32'h0200);
    dm_done  = 1'b1;
    dm_rdata = 16'h1357;
    step();
    dm_done  = 1'b0;
    dm_rdata = '0;
    check("post_rst_wb_valid", 32'(wb_valid), 32'd1);
    check("post_rst_wb_data", 32'(wb_data), 32'h1357);

    // 6: halt is sticky and blocks further captures
    drive(1'b1, 16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_wb_valid", 32'(wb_valid), 32'd1);
    check("halt_wb_data", 32'(wb_data), 32'h00AA);
    check("halt_wb_err", 32'(wb_err), 32'd0);
    wb_count = 0;
    req_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (i[0]) drive(1'b1, 16'h0300, 16'h0000, 1'b0, 1'b1, 1'b1);
      else      drive(1'b1, 16'h4444, 16'h0000, 1'b0, 1'b0, 1'b1);
      step();
      if (wb_valid) wb_count++;
      if (dm_req) req_seen++;
    end
    idle_in();
    check("halt_no_more_wb", 32'(wb_count), 32'd0);
    check("halt_no_req", 32'(req_seen), 32'd0);
    check("halt_sticky", 32'(halted), 32'd1);
    rst = 1'b1;
    #1;
    check("halt_clr_by_rst", 32'(halted), 32'd0);
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
